i2c_target_regs: RTL and testbench
==================================

Name: i2c_target_regs

Overview:
- I2C target (slave) holding a small byte register file; it is the responder at the other end of the I2C bus driven by the team's APB-controlled I2C master.
- Used as the bus-functional peer in system simulation and as synthesizable on-chip I2C target logic.
- Samples SCL/SDA on PCLK (oversampled, no SCL-domain logic) and drives SDA open-drain via an output-enable.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit address this target acknowledges.
- REG_AW, 2, register pointer width; register file depth = 2**REG_AW bytes.

Ports:
- PCLK  in  1  system clock; all logic is on its rising edge.
- PRESET  in  1  synchronous reset, active-high.
- SCL  in  1  bus clock as seen on the pad (asynchronous).
- SDA_IN  in  1  bus data as seen on the pad (asynchronous).
- SDA_OE  out  1  1 = pull SDA low; 0 = release (pad is open-drain).
- LOC_ADDR  in  REG_AW  local combinational read address.
- LOC_RDATA  out  8  register[LOC_ADDR], combinational.
- WR_STB  out  1  one-PCLK pulse when a register is written from I2C.
- WR_ADDR  out  REG_AW  register index of the write; valid with WR_STB.
- WR_DATA  out  8  byte written; valid with WR_STB.
- BUSY  out  1  high from an addressed (ACKed) START until STOP or idle return.

Behaviour:
- Input path: SCL and SDA_IN each pass through 2-FF synchronizers, then a 1-FF history register for edge detection. Requirement: PCLK >= 8x SCL frequency.
- START: synced SDA falls while synced SCL is high. STOP: synced SDA rises while synced SCL is high. Both are recognised in every state.
  - START (including repeated START) -> ADDR with bit count 0.
  - STOP -> IDLE; SDA_OE=0 and BUSY=0 on the next PCLK.
- Data is sampled on the synced SCL rising edge. SDA_OE changes only on the synced SCL falling edge, except on STOP or reset.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- ADDR: shift in 8 bits MSB first (7 address bits + R/W).
  - Mismatch -> IGNORE; SDA is never driven until the next START.
  - Match -> on the 8th SCL falling edge, SDA_OE=1 and BUSY=1; hold through the 9th clock and release on the 9th falling edge.
  - Next state: R/W=0 -> PTR; R/W=1 -> RDATA with the shift register loaded from reg[ptr].
- PTR: first written byte sets ptr = byte[REG_AW-1:0]; upper bits are ignored. ACK as in ADDR; next state WDATA.
- WDATA: each byte is ACKed.
  - On the 8th SCL rising edge: reg[ptr] <= byte; WR_STB=1 for exactly one PCLK with WR_ADDR=ptr and WR_DATA=byte.
  - ptr then increments modulo 2**REG_AW (wraps 3->0 at default).
- RDATA: drive SDA_OE = ~bit, MSB first, each bit updated on an SCL falling edge. After the 8th falling edge, SDA_OE=0 (released) and state -> RDATA_ACK.
- RDATA_ACK: sample SDA on the 9th rising edge.
  - Low (ACK): ptr++ with wrap; load reg[ptr]; continue in RDATA.
  - High (NACK): -> IGNORE, keeping BUSY=1 until STOP.
- STOP or START mid-byte: partial byte discarded; no WR_STB; ptr unchanged.
- ptr persists across transactions; only reset clears it.
- Reset values: SDA_OE=0, BUSY=0, WR_STB=0, WR_ADDR=0, WR_DATA=0, all registers 8'h00, ptr=0, state IDLE, synchronizers loaded with 1 (bus idle).
- Reset asserted mid-transfer: SDA is released on the next PCLK. After reset, the target ignores the bus until a fresh START.

Optional Feature:
- Macro I2C_TARGET_GLITCH_FILTER_EN.
- Defined: after the synchronizers, SCL and SDA each pass a 3-sample majority filter. This rejects 1-PCLK glitches and adds 2 PCLK of detection latency; the PCLK >= 8x SCL rule still holds.
- Undefined: no filter; a single-cycle glitch on SCL is treated as a real edge.

Test Plan:
- Write: START, 0xA0, ptr 0x01, data 0x5A, 0xC3, STOP -> ACK on all 4 bytes; WR_STB pulses (1,0x5A) then (2,0xC3); LOC_ADDR=2 gives LOC_RDATA=0xC3.
- Random read: START, 0xA0, ptr 0x01, repeated START, 0xA1, read 2 bytes (ACK then NACK), STOP -> returns 0x5A, 0xC3; BUSY falls after STOP.
- Wrap: ptr 0x03, write 0x11, 0x22 -> reg3=0x11, reg0=0x22; a following read from ptr 3 returns 0x11, 0x22.
- Address mismatch: START, 0xA2, one data byte, STOP -> SDA_OE stays 0 throughout; no WR_STB; BUSY stays 0.
- Abort: STOP after 5 bits of a data byte -> no WR_STB; registers unchanged; next transaction works normally.
- Reset mid-read, with SDA_OE=1 while driving a 0 bit -> SDA_OE=0 on the next PCLK; all registers 0x00; a subsequent read of reg0 returns 0x00.

Source files
------------

// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target (slave) with a small byte register file.
// SCL/SDA are oversampled on PCLK (PCLK >= 8x SCL); SDA is driven open-drain
// through SDA_OE. Writes: address, pointer byte, then data bytes with
// auto-increment. Reads: data from reg[ptr] with auto-increment on ACK.
// Optional macro I2C_TARGET_GLITCH_FILTER_EN adds a 3-sample majority filter
// on SCL and SDA after the synchronizers.
`timescale 1ns/1ps

module i2c_target_regs #(
    parameter logic [6:0] TARGET_ADDR = 7'h50,
    parameter int         REG_AW      = 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              SCL,
    input  logic              SDA_IN,
    output logic              SDA_OE,
    input  logic [REG_AW-1:0] LOC_ADDR,
    output logic [7:0]        LOC_RDATA,
    output logic              WR_STB,
    output logic [REG_AW-1:0] WR_ADDR,
    output logic [7:0]        WR_DATA,
    output logic              BUSY
);

    localparam int DEPTH = 2 ** REG_AW;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_IGNORE    = 4'd9
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning: 2-FF synchronizers (optional majority filter),
    // then a one-deep history for edge detection. Idle bus level is 1.
    // ------------------------------------------------------------------
    logic scl_s1_q, scl_s2_q, sda_s1_q, sda_s2_q;
    logic scl_c, sda_c;
    logic scl_h_q, sda_h_q;

    // Two-stage synchronizers for the asynchronous pad inputs.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
        end else begin
            scl_s1_q <= SCL;
            scl_s2_q <= scl_s1_q;
            sda_s1_q <= SDA_IN;
            sda_s2_q <= sda_s1_q;
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic scl_m1_q, scl_m2_q, sda_m1_q, sda_m2_q;
    logic scl_f_q, sda_f_q;

    // Majority-of-three filter: a 1-PCLK pulse never wins the vote.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            scl_m1_q <= 1'b1;
            scl_m2_q <= 1'b1;
            sda_m1_q <= 1'b1;
            sda_m2_q <= 1'b1;
            scl_f_q  <= 1'b1;
            sda_f_q  <= 1'b1;
        end else begin
            scl_m1_q <= scl_s2_q;
            scl_m2_q <= scl_m1_q;
            sda_m1_q <= sda_s2_q;
            sda_m2_q <= sda_m1_q;
            scl_f_q  <= maj3(scl_s2_q, scl_m1_q, scl_m2_q);
            sda_f_q  <= maj3(sda_s2_q, sda_m1_q, sda_m2_q);
        end
    end

    assign scl_c = scl_f_q;
    assign sda_c = sda_f_q;
`else
    assign scl_c = scl_s2_q;
    assign sda_c = sda_s2_q;
`endif

    // History registers used to detect edges of the conditioned lines.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            scl_h_q <= 1'b1;
            sda_h_q <= 1'b1;
        end else begin
            scl_h_q <= scl_c;
            sda_h_q <= sda_c;
        end
    end

    logic scl_rise, scl_fall, start_s, stop_s;
    assign scl_rise = scl_c & ~scl_h_q;
    assign scl_fall = ~scl_c & scl_h_q;
    assign start_s  = scl_c & scl_h_q & sda_h_q & ~sda_c;
    assign stop_s   = scl_c & scl_h_q & ~sda_h_q & sda_c;

    // ------------------------------------------------------------------
    // Protocol state machine and register file
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [REG_AW-1:0] ptr_q, ptr_d;
    logic              oe_q, oe_d;
    logic              busy_q, busy_d;
    logic              stb_q, stb_d;
    logic [REG_AW-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        regs_q [DEPTH];
    logic [7:0]        regs_d [DEPTH];
    logic [7:0]        byte_in;
    logic [7:0]        rd_byte;

    assign byte_in = {shift_q[6:0], sda_c};
    assign rd_byte = regs_q[ptr_q];

    // Next-state, bit counting, SDA drive and register write decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        ptr_d   = ptr_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        stb_d   = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        regs_d  = regs_q;

        if (stop_s) begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
        end else if (start_s) begin
            state_d = ST_ADDR;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise && (cnt_q < 4'd8)) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 4'd1;
                        // Eighth data bit completes a register write.
                        if ((state_q == ST_WDATA) && (cnt_q == 4'd7)) begin
                            regs_d[ptr_q] = byte_in;
                            stb_d         = 1'b1;
                            waddr_d       = ptr_q;
                            wdata_d       = byte_in;
                            ptr_d         = ptr_q + REG_AW'(1);
                        end else begin
                            stb_d = 1'b0;
                        end
                    end else if (scl_fall && (cnt_q == 4'd8)) begin
                        if (state_q == ST_ADDR) begin
                            if (shift_q[7:1] == TARGET_ADDR) begin
                                oe_d    = 1'b1;
                                busy_d  = 1'b1;
                                state_d = ST_ADDR_ACK;
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end else if (state_q == ST_PTR) begin
                            ptr_d   = shift_q[REG_AW-1:0];
                            oe_d    = 1'b1;
                            state_d = ST_PTR_ACK;
                        end else begin
                            oe_d    = 1'b1;
                            state_d = ST_WDATA_ACK;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        cnt_d = 4'd0;
                        // R/W bit is still in shift_q[0].
                        if (shift_q[0]) begin
                            state_d = ST_RDATA;
                            shift_d = rd_byte;
                            oe_d    = ~rd_byte[7];
                        end else begin
                            state_d = ST_PTR;
                            oe_d    = 1'b0;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end

                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        oe_d    = 1'b0;
                        cnt_d   = 4'd0;
                        state_d = ST_WDATA;
                    end else begin
                        state_d = state_q;
                    end
                end

                ST_RDATA: begin
                    if (scl_rise && (cnt_q < 4'd8)) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall && (cnt_q == 4'd8)) begin
                        oe_d    = 1'b0;
                        cnt_d   = 4'd0;
                        state_d = ST_RDATA_ACK;
                    end else if (scl_fall && (cnt_q != 4'd0)) begin
                        shift_d = {shift_q[6:0], 1'b0};
                        oe_d    = ~shift_q[6];
                    end else begin
                        state_d = state_q;
                    end
                end

                ST_RDATA_ACK: begin
                    // cnt_q == 1 marks that the master ACKed this byte.
                    if (scl_rise) begin
                        if (!sda_c) begin
                            ptr_d = ptr_q + REG_AW'(1);
                            cnt_d = 4'd1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end else if (scl_fall && (cnt_q == 4'd1)) begin
                        cnt_d   = 4'd0;
                        shift_d = rd_byte;
                        oe_d    = ~rd_byte[7];
                        state_d = ST_RDATA;
                    end else begin
                        state_d = state_q;
                    end
                end

                ST_IDLE, ST_IGNORE: begin
                    state_d = state_q;
                end

                default: begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            shift_q <= 8'h00;
            ptr_q   <= '0;
            oe_q    <= 1'b0;
            busy_q  <= 1'b0;
            stb_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            ptr_q   <= ptr_d;
            oe_q    <= oe_d;
            busy_q  <= busy_d;
            stb_q   <= stb_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            regs_q  <= regs_d;
        end
    end

    assign SDA_OE    = oe_q;
    assign BUSY      = busy_q;
    assign WR_STB    = stb_q;
    assign WR_ADDR   = waddr_q;
    assign WR_DATA   = wdata_q;
    assign LOC_RDATA = regs_q[LOC_ADDR];

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed plus randomized bench for i2c_target_regs: an I2C master bus model
// drives SCL/SDA, a byte-level reference model predicts register contents,
// pointer movement, write strobes and read data.
`timescale 1ns/1ps

module tb_i2c_target_regs;

    localparam time Q = 50;   // quarter SCL period; SCL = 200 ns, PCLK = 10 ns

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       scl;
    logic       sda_m;
    logic       sda_line;
    logic       SDA_OE;
    logic [1:0] LOC_ADDR;
    logic [7:0] LOC_RDATA;
    logic       WR_STB;
    logic [1:0] WR_ADDR;
    logic [7:0] WR_DATA;
    logic       BUSY;

    assign sda_line = sda_m & ~SDA_OE;

    i2c_target_regs dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .SCL       (scl),
        .SDA_IN    (sda_line),
        .SDA_OE    (SDA_OE),
        .LOC_ADDR  (LOC_ADDR),
        .LOC_RDATA (LOC_RDATA),
        .WR_STB    (WR_STB),
        .WR_ADDR   (WR_ADDR),
        .WR_DATA   (WR_DATA),
        .BUSY      (BUSY)
    );

    always #5 PCLK = ~PCLK;

    // Bus monitors: log every strobed write and count SDA_OE/BUSY cycles.
    int         stb_cnt  = 0;
    int         oe_cnt   = 0;
    int         busy_cnt = 0;
    logic [9:0] stb_log [1024];

    always @(negedge PCLK) begin
        if (WR_STB) begin
            stb_log[stb_cnt % 1024] <= {WR_ADDR, WR_DATA};
            stb_cnt <= stb_cnt + 1;
        end
        if (SDA_OE) oe_cnt <= oe_cnt + 1;
        if (BUSY) busy_cnt <= busy_cnt + 1;
    end

    // Reference model and scratch buffers.
    int         total = 0;
    int         bad   = 0;
    logic [7:0] mreg [4];
    logic [1:0] mptr;
    logic [7:0] wbuf [4];
    logic [7:0] rbuf [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // ---------------- bus-level master primitives ----------------
    task automatic bus_start();
        sda_m = 1'b1; #Q;
        scl   = 1'b1; #Q;
        sda_m = 1'b0; #Q;
        scl   = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; #Q;
        scl   = 1'b1; #Q;
        sda_m = 1'b1; #(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    #Q;
        scl   = 1'b1; #(2 * Q);
        scl   = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; #Q;
        scl   = 1'b1; #Q;
        ack   = (sda_line === 1'b0); #Q;
        scl   = 1'b0; #Q;
    endtask

    task automatic recv_byte(input logic m_ack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; #Q;
            scl   = 1'b1; #Q;
            b[i]  = sda_line; #Q;
            scl   = 1'b0; #Q;
        end
        send_bit(m_ack ? 1'b0 : 1'b1);
    endtask

    // ---------------- transaction-level tasks with model update ----------------
    task automatic chk_regs();
        for (int i = 0; i < 4; i++) begin
            LOC_ADDR = 2'(i); #1;
            chk($sformatf("loc_rdata[%0d]", i), {24'h0, LOC_RDATA}, {24'h0, mreg[i]});
        end
    endtask

    task automatic wr_txn(input logic [7:0] p, input int n);
        logic ack;
        int   base;
        base = stb_cnt;
        bus_start();
        send_byte(8'hA0, ack);  chk("wr_addr_ack", {31'h0, ack}, 32'h1);
        send_byte(p, ack);      chk("wr_ptr_ack", {31'h0, ack}, 32'h1);
        mptr = p[1:0];
        for (int i = 0; i < n; i++) begin
            send_byte(wbuf[i], ack);
            chk("wr_data_ack", {31'h0, ack}, 32'h1);
            chk("wr_stb_count", stb_cnt, base + i + 1);
            chk("wr_stb_addr_data", {22'h0, stb_log[(base + i) % 1024]}, {22'h0, mptr, wbuf[i]});
            mreg[mptr] = wbuf[i];
            mptr       = mptr + 2'd1;
        end
        bus_stop();
        chk("wr_busy_after_stop", {31'h0, BUSY}, 32'h0);
    endtask

    // setp=1: random read (pointer byte then repeated START); setp=0: current-address read.
    task automatic rd_txn(input logic setp, input logic [7:0] p, input int n);
        logic ack;
        bus_start();
        if (setp) begin
            send_byte(8'hA0, ack); chk("rd_waddr_ack", {31'h0, ack}, 32'h1);
            send_byte(p, ack);     chk("rd_ptr_ack", {31'h0, ack}, 32'h1);
            mptr = p[1:0];
            bus_start();
        end
        send_byte(8'hA1, ack);     chk("rd_raddr_ack", {31'h0, ack}, 32'h1);
        for (int i = 0; i < n; i++) begin
            recv_byte(i < n - 1, rbuf[i]);
            chk("rd_data", {24'h0, rbuf[i]}, {24'h0, mreg[mptr]});
            if (i < n - 1) mptr = mptr + 2'd1;
        end
        chk("rd_busy_before_stop", {31'h0, BUSY}, 32'h1);
        bus_stop();
        chk("rd_busy_after_stop", {31'h0, BUSY}, 32'h0);
    endtask

    initial begin
        logic ack;
        int   s_oe, s_stb, s_busy;

        PRESET   = 1'b1;
        scl      = 1'b1;
        sda_m    = 1'b1;
        LOC_ADDR = 2'd0;
        for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
        mptr = 2'd0;
        repeat (4) @(negedge PCLK);

        // Reset state
        chk("rst_sda_oe", {31'h0, SDA_OE}, 32'h0);
        chk("rst_busy", {31'h0, BUSY}, 32'h0);
        chk("rst_wr_stb", {31'h0, WR_STB}, 32'h0);
        chk("rst_wr_addr", {30'h0, WR_ADDR}, 32'h0);
        chk("rst_wr_data", {24'h0, WR_DATA}, 32'h0);
        @(negedge PCLK);
        PRESET = 1'b0;
        repeat (4) @(negedge PCLK);
        chk_regs();

        // Write 0x5A, 0xC3 from pointer 1
        wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
        wr_txn(8'h01, 2);
        LOC_ADDR = 2'd2; #1;
        chk("loc2_after_write", {24'h0, LOC_RDATA}, 32'hC3);
        chk_regs();

        // Random read from pointer 1 with repeated START
        rd_txn(1'b1, 8'h01, 2);
        chk("rd_byte0", {24'h0, rbuf[0]}, 32'h5A);
        chk("rd_byte1", {24'h0, rbuf[1]}, 32'hC3);

        // Pointer wrap 3 -> 0 on write and on read
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        wr_txn(8'h03, 2);
        LOC_ADDR = 2'd3; #1; chk("wrap_reg3", {24'h0, LOC_RDATA}, 32'h11);
        LOC_ADDR = 2'd0; #1; chk("wrap_reg0", {24'h0, LOC_RDATA}, 32'h22);
        rd_txn(1'b1, 8'h03, 2);
        chk("wrap_rd0", {24'h0, rbuf[0]}, 32'h11);
        chk("wrap_rd1", {24'h0, rbuf[1]}, 32'h22);

        // Address mismatch: target must stay off the bus
        s_oe = oe_cnt; s_stb = stb_cnt; s_busy = busy_cnt;
        bus_start();
        send_byte(8'hA2, ack); chk("mis_addr_nack", {31'h0, ack}, 32'h0);
        send_byte(8'h3C, ack); chk("mis_data_nack", {31'h0, ack}, 32'h0);
        bus_stop();
        chk("mis_oe_cycles", oe_cnt - s_oe, 0);
        chk("mis_stb_count", stb_cnt - s_stb, 0);
        chk("mis_busy_cycles", busy_cnt - s_busy, 0);
        chk_regs();

        // Abort: STOP after 5 bits of a data byte
        s_stb = stb_cnt;
        bus_start();
        send_byte(8'hA0, ack); chk("abort_addr_ack", {31'h0, ack}, 32'h1);
        send_byte(8'h00, ack); chk("abort_ptr_ack", {31'h0, ack}, 32'h1);
        mptr = 2'd0;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        bus_stop();
        chk("abort_stb_count", stb_cnt - s_stb, 0);
        chk_regs();
        rd_txn(1'b0, 8'h00, 1);
        chk("abort_ptr_kept", {24'h0, rbuf[0]}, 32'h22);
        wbuf[0] = 8'h77;
        wr_txn(8'h02, 1);
        rd_txn(1'b1, 8'h02, 1);
        chk("abort_recover", {24'h0, rbuf[0]}, 32'h77);

        // Reset while the target drives a 0 bit of a read
        wbuf[0] = 8'h0F;
        wr_txn(8'h01, 1);
        bus_start();
        send_byte(8'hA0, ack);
        send_byte(8'h01, ack);
        bus_start();
        send_byte(8'hA1, ack); chk("rstrd_addr_ack", {31'h0, ack}, 32'h1);
        #10;
        chk("rstrd_oe_driving", {31'h0, SDA_OE}, 32'h1);
        @(negedge PCLK);
        PRESET = 1'b1;
        @(posedge PCLK); #1;
        chk("rstrd_oe_released", {31'h0, SDA_OE}, 32'h0);
        for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
        mptr = 2'd0;
        repeat (3) @(negedge PCLK);
        chk("rstrd_busy", {31'h0, BUSY}, 32'h0);
        PRESET = 1'b0;
        #Q; scl = 1'b1; #(2 * Q);
        chk_regs();
        rd_txn(1'b1, 8'h00, 1);
        chk("rstrd_reg0", {24'h0, rbuf[0]}, 32'h00);

        // Randomized writes and reads against the model
        for (int it = 0; it < 10; it++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
            wr_txn(8'($urandom), n);
            chk_regs();
            n = $urandom_range(1, 4);
            rd_txn(1'($urandom_range(0, 1)), 8'($urandom), n);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
